// File: rtl/drive_seq_pkg.sv
// drive_seq_pkg: shared types and width helpers for the staggered drive-bank
// sequencer (drive_bank_sequencer and its thermometer decoder).
// Optional feature macro used by the top: DRV_SEQ_FORCE_EN.

package drive_seq_pkg;

   // Sequencer phases: settled off, stepping up, settled on, stepping down.
   typedef enum logic [1:0] {
      OFF     = 2'd0,
      RAMP_UP = 2'd1,
      ON      = 2'd2,
      RAMP_DN = 2'd3
   } seq_state_t;

   // Width of the level counter, which must hold every value 0..nbank.
   function automatic int lvl_width(input int nbank);
      return $clog2(nbank + 1);
   endfunction

   // Width of the gap counter, which holds 0..gap-1; never narrower than 1 bit
   // so that GAP=1 still gets a legal (always-zero) counter.
   function automatic int gc_width(input int gap);
      return (gap < 2) ? 1 : $clog2(gap);
   endfunction

endpackage

// File: rtl/drive_seq_therm.sv
// drive_seq_therm: combinational level-to-thermometer decoder.
// Bit i of the output is set exactly when i < lvl, so the enable pattern is
// always a contiguous run of ones starting at bank 0.

module drive_seq_therm
   import drive_seq_pkg::*;
#(
   parameter  int NBANK = 8,
   localparam int LW    = lvl_width(NBANK)
)
(
   input  logic [LW-1:0]    lvl,
   output logic [NBANK-1:0] therm
);

   // Decode the level into a hole-free thermometer code.
   always_comb begin
      therm = '0;
      for (int i = 0; i < NBANK; i++) begin
         therm[i] = (32'(i) < 32'(lvl));
      end
   end

endmodule

// File: rtl/drive_bank_sequencer.sv
// drive_bank_sequencer: staggered enable sequencer for a row of high-drive
// buffer banks. Banks are switched one at a time with GAP cycles between
// steps so supply di/dt and inrush stay bounded. A reversal of EN mid-ramp
// restarts the gap timer and walks back from the current level.
// Optional feature: define DRV_SEQ_FORCE_EN to add the FORCE_ON bypass input,
// which jumps straight to all-banks-on from any state.

module drive_bank_sequencer
   import drive_seq_pkg::*;
#(
   parameter int NBANK = 8,
   parameter int GAP   = 4
)
(
   input  logic             CLK,
   input  logic             RN,
   input  logic             EN,
`ifdef DRV_SEQ_FORCE_EN
   input  logic             FORCE_ON,
`endif
   output logic [NBANK-1:0] BANK_EN,
   output logic             READY,
   output logic             IDLE,
   output logic             BUSY
);

   localparam int LW = lvl_width(NBANK);
   localparam int GW = gc_width(GAP);

   localparam logic [LW-1:0] LVL_ZERO = '0;
   localparam logic [LW-1:0] LVL_ONE  = LW'(1);
   localparam logic [LW-1:0] LVL_TOP  = LW'(NBANK - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(NBANK);
   localparam logic [GW-1:0] GC_ZERO  = '0;
   localparam logic [GW-1:0] GC_ONE   = GW'(1);
   localparam logic [GW-1:0] GC_LAST  = GW'(GAP - 1);

   seq_state_t       state_q, state_d;
   logic [LW-1:0]    lvl_q, lvl_d;
   logic [GW-1:0]    gc_q, gc_d;
   logic [NBANK-1:0] bank_en_q, bank_en_d;
   logic             ready_q, ready_d;
   logic             idle_q, idle_d;
   logic             busy_q, busy_d;
   logic             force_req;

`ifdef DRV_SEQ_FORCE_EN
   assign force_req = FORCE_ON;
`else
   assign force_req = 1'b0;
`endif

   // Next-state logic: the bypass wins, otherwise settle/step/reverse by phase.
   always_comb begin
      state_d = state_q;
      lvl_d   = lvl_q;
      gc_d    = gc_q;
      if (force_req) begin
         state_d = ON;
         lvl_d   = LVL_FULL;
         gc_d    = GC_ZERO;
      end else begin
         case (state_q)
            OFF: begin
               if (EN) begin
                  state_d = RAMP_UP;
                  lvl_d   = LVL_ONE;
                  gc_d    = GC_ZERO;
               end
            end
            RAMP_UP: begin
               if (!EN) begin
                  state_d = RAMP_DN;
                  gc_d    = GC_ZERO;
               end else if (gc_q == GC_LAST) begin
                  gc_d  = GC_ZERO;
                  lvl_d = lvl_q + LVL_ONE;
                  if (lvl_q == LVL_TOP) begin
                     state_d = ON;
                  end
               end else begin
                  gc_d = gc_q + GC_ONE;
               end
            end
            ON: begin
               if (!EN) begin
                  state_d = RAMP_DN;
                  lvl_d   = LVL_TOP;
                  gc_d    = GC_ZERO;
               end
            end
            RAMP_DN: begin
               if (EN) begin
                  state_d = RAMP_UP;
                  gc_d    = GC_ZERO;
               end else if (gc_q == GC_LAST) begin
                  gc_d  = GC_ZERO;
                  lvl_d = lvl_q - LVL_ONE;
                  if (lvl_q == LVL_ONE) begin
                     state_d = OFF;
                  end
               end else begin
                  gc_d = gc_q + GC_ONE;
               end
            end
            default: begin
               state_d = OFF;
               lvl_d   = LVL_ZERO;
               gc_d    = GC_ZERO;
            end
         endcase
      end
   end

   // Status flags are decoded from the next state so they line up with the
   // registered bank enables.
   always_comb begin
      ready_d = (state_d == ON);
      idle_d  = (state_d == OFF);
      busy_d  = (state_d == RAMP_UP) || (state_d == RAMP_DN);
   end

   drive_seq_therm #(
      .NBANK (NBANK)
   ) u_therm (
      .lvl   (lvl_d),
      .therm (bank_en_d)
   );

   // State, counters and registered outputs; reset forces everything off.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q   <= OFF;
         lvl_q     <= LVL_ZERO;
         gc_q      <= GC_ZERO;
         bank_en_q <= '0;
         ready_q   <= 1'b0;
         idle_q    <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         lvl_q     <= lvl_d;
         gc_q      <= gc_d;
         bank_en_q <= bank_en_d;
         ready_q   <= ready_d;
         idle_q    <= idle_d;
         busy_q    <= busy_d;
      end
   end

   assign BANK_EN = bank_en_q;
   assign READY   = ready_q;
   assign IDLE    = idle_q;
   assign BUSY    = busy_q;

endmodule
